// File: rtl/nvdla_csb_arbiter.sv
// Two-requester round-robin arbiter for the single NVDLA CSB config port.
// One transaction in flight; responses are routed back to the issuer, with an optional timeout.
module nvdla_csb_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 32,
  parameter int TO_CYC = 1024
) (
  input  logic          dla_csb_clk,
  input  logic          dla_reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdat,
  input  logic          req0_write,
  input  logic          req0_nposted,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdat,
  input  logic          req1_write,
  input  logic          req1_nposted,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_data,
  output logic          rsp0_err,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_data,
  output logic          rsp1_err,
  output logic          csb2nvdla_valid,
  input  logic          csb2nvdla_ready,
  output logic [AW-1:0] csb2nvdla_addr,
  output logic [DW-1:0] csb2nvdla_wdat,
  output logic          csb2nvdla_write,
  output logic          csb2nvdla_nposted,
  input  logic          nvdla2csb_valid,
  input  logic [DW-1:0] nvdla2csb_data,
  input  logic          nvdla2csb_wr_complete,
  output logic          busy,
  output logic          stray_rsp
);

  localparam int CW = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TO_CYC > 0) ? TO_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

  state_t        state_q, state_d;
  logic          last_grant_q;
  logic          hold_id_q;
  logic          hold_write_q;
  logic          hold_nposted_q;
  logic [AW-1:0] hold_addr_q;
  logic [DW-1:0] hold_wdat_q;
  logic [CW-1:0] to_cnt_q;

  logic          grant0, grant1;
  logic          exp_evt, wrong_evt, any_evt, timeout_hit;
  logic          cnt_clr, cnt_inc;
  logic          rsp_fire, rsp_err_d, stray_set;
  logic [DW-1:0] rsp_data_d;

  always_comb begin
    state_d     = state_q;
    grant0      = 1'b0;
    grant1      = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    rsp_fire    = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;
    stray_set   = 1'b0;
    any_evt     = nvdla2csb_valid | nvdla2csb_wr_complete;
    exp_evt     = hold_write_q ? nvdla2csb_wr_complete : nvdla2csb_valid;
    wrong_evt   = hold_write_q ? nvdla2csb_valid : nvdla2csb_wr_complete;
    timeout_hit = (TO_CYC != 0) && (to_cnt_q == TO_LAST);
    case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time is served.
        grant0    = req0_valid && (!req1_valid || last_grant_q);
        grant1    = req1_valid && (!req0_valid || !last_grant_q);
        stray_set = any_evt;
        if (grant0 || grant1) state_d = ISSUE;
      end
      ISSUE: begin
        stray_set = any_evt;
        if (csb2nvdla_ready) begin
          if (hold_write_q && !hold_nposted_q) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT_RSP;
            cnt_clr = 1'b1;
          end
        end
      end
      WAIT_RSP: begin
        stray_set = wrong_evt;
        // A real response beats a timeout landing in the same cycle.
        if (exp_evt) begin
          rsp_fire   = 1'b1;
          rsp_data_d = hold_write_q ? '0 : nvdla2csb_data;
          state_d    = IDLE;
        end else if (timeout_hit) begin
          rsp_fire  = 1'b1;
          rsp_err_d = 1'b1;
          state_d   = IDLE;
        end else if (TO_CYC != 0) begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge dla_csb_clk or posedge dla_reset) begin
    if (dla_reset) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      hold_id_q      <= 1'b0;
      hold_write_q   <= 1'b0;
      hold_nposted_q <= 1'b0;
      hold_addr_q    <= '0;
      hold_wdat_q    <= '0;
      to_cnt_q       <= '0;
      rsp0_valid     <= 1'b0;
      rsp0_data      <= '0;
      rsp0_err       <= 1'b0;
      rsp1_valid     <= 1'b0;
      rsp1_data      <= '0;
      rsp1_err       <= 1'b0;
      stray_rsp      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant0 || grant1) begin
        hold_id_q      <= grant1;
        last_grant_q   <= grant1;
        hold_addr_q    <= grant1 ? req1_addr    : req0_addr;
        hold_wdat_q    <= grant1 ? req1_wdat    : req0_wdat;
        hold_write_q   <= grant1 ? req1_write   : req0_write;
        hold_nposted_q <= grant1 ? req1_nposted : req0_nposted;
      end
      if (cnt_clr)      to_cnt_q <= '0;
      else if (cnt_inc) to_cnt_q <= to_cnt_q + 1'b1;
      // Response stage: one-cycle pulse, data/err held until the next pulse.
      rsp0_valid <= rsp_fire && !hold_id_q;
      rsp1_valid <= rsp_fire && hold_id_q;
      if (rsp_fire && !hold_id_q) begin
        rsp0_data <= rsp_data_d;
        rsp0_err  <= rsp_err_d;
      end
      if (rsp_fire && hold_id_q) begin
        rsp1_data <= rsp_data_d;
        rsp1_err  <= rsp_err_d;
      end
      if (stray_set) stray_rsp <= 1'b1;
    end
  end

  assign req0_ready        = grant0;
  assign req1_ready        = grant1;
  assign csb2nvdla_valid   = (state_q == ISSUE);
  assign csb2nvdla_addr    = hold_addr_q;
  assign csb2nvdla_wdat    = hold_wdat_q;
  assign csb2nvdla_write   = hold_write_q;
  assign csb2nvdla_nposted = hold_nposted_q;
  assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_nvdla_csb_arbiter.sv
// Self-checking bench for nvdla_csb_arbiter: vector table plus contention, timeout and reset sequences.
`timescale 1ns/1ps
module tb_nvdla_csb_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req0_write, req0_nposted;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdat;
  logic          req1_valid, req1_ready, req1_write, req1_nposted;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdat;
  logic          rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic          csb2nvdla_valid, csb2nvdla_ready, csb2nvdla_write, csb2nvdla_nposted;
  logic [AW-1:0] csb2nvdla_addr;
  logic [DW-1:0] csb2nvdla_wdat;
  logic          nvdla2csb_valid, nvdla2csb_wr_complete;
  logic [DW-1:0] nvdla2csb_data;
  logic          busy, stray_rsp;

  nvdla_csb_arbiter #(.AW(AW), .DW(DW), .TO_CYC(TO)) dut (
    .dla_csb_clk(clk), .dla_reset(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_wdat(req0_wdat), .req0_write(req0_write), .req0_nposted(req0_nposted),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_wdat(req1_wdat), .req1_write(req1_write), .req1_nposted(req1_nposted),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .csb2nvdla_valid(csb2nvdla_valid), .csb2nvdla_ready(csb2nvdla_ready),
    .csb2nvdla_addr(csb2nvdla_addr), .csb2nvdla_wdat(csb2nvdla_wdat),
    .csb2nvdla_write(csb2nvdla_write), .csb2nvdla_nposted(csb2nvdla_nposted),
    .nvdla2csb_valid(nvdla2csb_valid), .nvdla2csb_data(nvdla2csb_data),
    .nvdla2csb_wr_complete(nvdla2csb_wr_complete),
    .busy(busy), .stray_rsp(stray_rsp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  typedef struct {
    logic          id;
    logic          write;
    logic          np;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat;
    int            rdy_dly;
    int            rsp_dly;
    logic [DW-1:0] rdata;
    logic          exp_rsp;
    logic [DW-1:0] exp_data;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rsp0_valid || rsp1_valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: rsp0_valid=%0b rsp1_valid=%0b, want none (t=%0t)",
                 rsp0_valid, rsp1_valid, $time);
      end else begin
        e = sb.pop_front();
        chk("rsp_both", 32'(rsp0_valid & rsp1_valid), 32'd0);
        chk("rsp_id", 32'(rsp1_valid), 32'(e.id));
        chk("rsp_data", e.id ? rsp1_data : rsp0_data, e.data);
        chk("rsp_err", 32'(e.id ? rsp1_err : rsp0_err), 32'(e.err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drive_req(input logic id, input logic v, input logic w, input logic np,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!id) begin
      req0_valid = v; req0_write = w; req0_nposted = np; req0_addr = a; req0_wdat = d;
    end else begin
      req1_valid = v; req1_write = w; req1_nposted = np; req1_addr = a; req1_wdat = d;
    end
  endtask

  // Grant, CSB issue with rdy_dly stall cycles, accept; ends at the negedge after accept.
  task automatic issue_req(input logic id, input logic w, input logic np,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input int rdy_dly,
                           input logic push, input logic [DW-1:0] edata, input logic eerr,
                           input logic ebusy, output logic ok);
    logic rdy;
    ok = 1'b0;
    @(posedge clk); #1;
    drive_req(id, 1'b1, w, np, a, d);
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      rdy = id ? req1_ready : req0_ready;
      if (rdy) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("grant", 32'(ok), 32'd1);
    if (!ok) begin
      drive_req(id, 1'b0, 1'b0, 1'b0, '0, '0);
      return;
    end
    @(posedge clk); #1;
    drive_req(id, 1'b0, 1'b0, 1'b0, '0, '0);
    if (push) sb.push_back('{id: id, data: edata, err: eerr});
    for (int k = 0; k <= rdy_dly; k++) begin
      if (k == rdy_dly) csb2nvdla_ready = 1'b1;
      @(negedge clk);
      chk("issue_valid", 32'(csb2nvdla_valid), 32'd1);
      chk("issue_addr", 32'(csb2nvdla_addr), 32'(a));
      chk("issue_wdat", csb2nvdla_wdat, d);
      chk("issue_flags", 32'({csb2nvdla_write, csb2nvdla_nposted}), 32'({w, np}));
      @(posedge clk); #1;
    end
    csb2nvdla_ready = 1'b0;
    @(negedge clk);
    chk("busy_after_accept", 32'(busy), 32'(ebusy));
  endtask

  task automatic run_vec(input vec_t v);
    logic ok;
    issue_req(v.id, v.write, v.np, v.addr, v.wdat, v.rdy_dly, v.exp_rsp, v.exp_data,
              1'b0, v.exp_rsp, ok);
    if (ok && v.exp_rsp) begin
      repeat (v.rsp_dly) @(posedge clk);
      #1;
      nvdla2csb_data = v.rdata;
      if (v.write) nvdla2csb_wr_complete = 1'b1;
      else         nvdla2csb_valid       = 1'b1;
      @(posedge clk); #1;
      nvdla2csb_valid       = 1'b0;
      nvdla2csb_wr_complete = 1'b0;
      for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
      chk("rsp_seen", sb.size(), 32'd0);
      @(negedge clk);
      chk("rsp_single_pulse", 32'(rsp0_valid | rsp1_valid), 32'd0);
      chk("rsp_data_hold", v.id ? rsp1_data : rsp0_data, v.exp_data);
    end
    chk("stray_idle", 32'(stray_rsp), 32'd0);
  endtask

  initial begin
    int   ng;
    int   nb;
    logic last_id;
    logic ok;

    //          id    wr    np    addr      wdat          rdy rsp rdata         rsp   exp_data
    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0040, 32'h00000000, 0,  3,  32'h12345678, 1'b1, 32'h12345678};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h0100, 32'hCAFE0001, 4,  0,  32'h00000000, 1'b0, 32'h00000000};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h0200, 32'hA5A5A5A5, 1,  2,  32'hDEADBEEF, 1'b1, 32'h00000000};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h0344, 32'h00000000, 2,  1,  32'h89ABCDEF, 1'b1, 32'h89ABCDEF};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h0348, 32'h00000001, 0,  5,  32'hFFFFFFFF, 1'b1, 32'h00000000};
    // Response lands in the last WAIT_RSP cycle before timeout: the response must win.
    vecs[5] = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 32'h00000000, 3,  TO-1, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF};

    rst = 1'b0;
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive_req(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    csb2nvdla_ready       = 1'b0;
    nvdla2csb_valid       = 1'b0;
    nvdla2csb_wr_complete = 1'b0;
    nvdla2csb_data        = '0;
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_csb_valid", 32'(csb2nvdla_valid), 32'd0);
    chk("rst_csb_addr", 32'(csb2nvdla_addr), 32'd0);
    chk("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    chk("rst_rsp_data", rsp0_data | rsp1_data, 32'd0);
    chk("rst_stray", 32'(stray_rsp), 32'd0);
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Contention: both held valid, posted writes, CSB always ready -> 0,1,0,1.
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 1'b1, 1'b0, 16'h0010, 32'h10000000);
    drive_req(1'b1, 1'b1, 1'b1, 1'b0, 16'h0020, 32'h20000000);
    csb2nvdla_ready = 1'b1;
    ng = 0;
    last_id = 1'b0;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      @(negedge clk);
      if (csb2nvdla_valid)
        chk("cont_addr", 32'(csb2nvdla_addr), last_id ? 32'h20 : 32'h10);
      if (req0_ready || req1_ready) begin
        chk("cont_onehot", 32'(req0_ready & req1_ready), 32'd0);
        chk($sformatf("cont_order%0d", ng), 32'(req1_ready), 32'(ng % 2));
        last_id = req1_ready;
        ng++;
      end
    end
    chk("cont_count", ng, 32'd4);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive_req(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1 csb2nvdla_ready = 1'b0;
    @(negedge clk);
    chk("cont_idle", 32'(busy), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Timeout: read on req1 with no response.
    issue_req(1'b1, 1'b0, 1'b0, 16'h0400, 32'h0, 0, 1'b1, 32'h0, 1'b1, 1'b1, ok);
    nb = 1;
    for (int k = 0; k < 30 && busy; k++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("timeout_cycles", nb, TO);
    @(negedge clk);
    chk("timeout_rsp_seen", sb.size(), 32'd0);
    chk("stray_before_late", 32'(stray_rsp), 32'd0);
    @(posedge clk); #1;
    nvdla2csb_valid = 1'b1;
    nvdla2csb_data  = 32'h77777777;
    @(posedge clk); #1;
    nvdla2csb_valid = 1'b0;
    chk("stray_late", 32'(stray_rsp), 32'd1);

    // Reset in WAIT_RSP abandons the read; a later response is stray only.
    issue_req(1'b0, 1'b0, 1'b0, 16'h0500, 32'h0, 1, 1'b0, 32'h0, 1'b0, 1'b1, ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_csb_valid", 32'(csb2nvdla_valid), 32'd0);
    chk("mid_rst_rsp0_data", rsp0_data, 32'd0);
    chk("mid_rst_rsp1_err", 32'(rsp1_err), 32'd0);
    chk("mid_rst_stray", 32'(stray_rsp), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    nvdla2csb_valid = 1'b1;
    nvdla2csb_data  = 32'h00000055;
    @(posedge clk); #1;
    nvdla2csb_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_stray", 32'(stray_rsp), 32'd1);
    chk("post_rst_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
